// File: rtl/uart_frame_pkg.sv
// Shared constants and types for the UART frame parser: header bytes,
// default payload limit and the parser state encoding.
package uart_frame_pkg;

  localparam logic [7:0] HDR0            = 8'hAA;
  localparam logic [7:0] HDR1            = 8'h55;
  localparam int         DEFAULT_MAX_LEN = 16;

  typedef enum logic [2:0] {
    HUNT0,
    HUNT1,
    CMD,
    LEN,
    PAY,
    CHK,
    DRAIN
  } state_t;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: DEPTH x 8 register file, synchronous write,
// combinational read. Out-of-range addresses are ignored on write and read 0.
module uart_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int DEPTH = DEFAULT_MAX_LEN
) (
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr,
  output logic [7:0] rdata
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_LIM = 5'(DEPTH);

  logic [7:0] mem [DEPTH];

  // Capture a payload byte into its slot when the parser writes one
  always_ff @(posedge clk) begin
    if (we && (waddr < DEPTH_LIM)) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

  assign rdata = (raddr < DEPTH_LIM) ? mem[raddr[AW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_frame_parser.sv
// Parses AA 55 CMD LEN payload CHK frames from a UART byte stream, checks the
// XOR checksum, then drains the stored payload over a valid/ready interface.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN     = DEFAULT_MAX_LEN,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic [7:0] rx_data,
  input  logic       po_flag,
  output logic [7:0] out_cmd,
  output logic [4:0] out_len,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_tmo,
  output logic       err_ovf
);

  localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]  MAX_LEN8 = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state;
  state_t        nxt_state;
  logic [7:0]    cmd_q;
  logic [4:0]    len_q;
  logic [7:0]    xor_q;
  logic [4:0]    wr_idx;
  logic [4:0]    rd_idx;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    rd_byte;
  logic          counting;
  logic          tmo_hit;
  logic          len_bad;
  logic          chk_match;
  logic          drain_last;
  logic          buf_we;
  logic          ev_ok;
  logic          ev_chk;
  logic          ev_len;
  logic          ev_tmo;
  logic          ev_ovf;

  assign counting   = (state == HUNT1) || (state == CMD) || (state == LEN) ||
                      (state == PAY)   || (state == CHK);
  assign tmo_hit    = counting && !po_flag && (tmo_cnt == TMO_LAST);
  assign len_bad    = (rx_data == 8'd0) || (rx_data > MAX_LEN8);
  assign chk_match  = (rx_data == xor_q);
  assign drain_last = (rd_idx == (len_q - 5'd1));
  assign buf_we     = (state == PAY) && po_flag && !s_rst;
  assign out_cmd    = cmd_q;
  assign out_len    = len_q;

  uart_frame_buf #(
    .DEPTH(MAX_LEN)
  ) u_buf (
    .clk  (sclk),
    .we   (buf_we),
    .waddr(wr_idx),
    .wdata(rx_data),
    .raddr(rd_idx),
    .rdata(rd_byte)
  );

  // State register; reset abandons any frame in progress
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state <= HUNT0;
    end else begin
      state <= nxt_state;
    end
  end

  // Next-state decode: a timeout wins only when no byte arrives that cycle
  always_comb begin
    nxt_state = state;
    if (tmo_hit) begin
      nxt_state = HUNT0;
    end else begin
      unique case (state)
        HUNT0: if (po_flag && (rx_data == HDR0)) nxt_state = HUNT1;
        HUNT1: begin
          if (po_flag) begin
            if (rx_data == HDR1)      nxt_state = CMD;
            else if (rx_data == HDR0) nxt_state = HUNT1;
            else                      nxt_state = HUNT0;
          end
        end
        CMD:   if (po_flag) nxt_state = LEN;
        LEN:   if (po_flag) nxt_state = len_bad ? HUNT0 : PAY;
        PAY:   if (po_flag && (wr_idx == (len_q - 5'd1))) nxt_state = CHK;
        CHK:   if (po_flag) nxt_state = chk_match ? DRAIN : HUNT0;
        DRAIN: if (out_ready && drain_last) nxt_state = HUNT0;
        default: nxt_state = HUNT0;
      endcase
    end
  end

  // Output decode: drain interface plus the per-cycle event conditions
  always_comb begin
    out_valid = (state == DRAIN);
    out_last  = (state == DRAIN) && drain_last;
    out_data  = (state == DRAIN) ? rd_byte : 8'h00;
    ev_ok     = (state == CHK) && po_flag && chk_match;
    ev_chk    = (state == CHK) && po_flag && !chk_match;
    ev_len    = (state == LEN) && po_flag && len_bad;
    ev_tmo    = tmo_hit;
    ev_ovf    = (state == DRAIN) && po_flag;
  end

  // Turn event conditions into registered single-cycle pulses
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      frame_ok <= 1'b0;
      err_chk  <= 1'b0;
      err_len  <= 1'b0;
      err_tmo  <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      frame_ok <= ev_ok;
      err_chk  <= ev_chk;
      err_len  <= ev_len;
      err_tmo  <= ev_tmo;
      err_ovf  <= ev_ovf;
    end
  end

  // Frame datapath: header fields, running XOR, indices and the idle timer
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      cmd_q   <= 8'h00;
      len_q   <= 5'd0;
      xor_q   <= 8'h00;
      wr_idx  <= 5'd0;
      rd_idx  <= 5'd0;
      tmo_cnt <= '0;
    end else begin
      if (po_flag || !counting || tmo_hit) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      case (state)
        CMD: begin
          if (po_flag) begin
            cmd_q <= rx_data;
            xor_q <= rx_data;
          end
        end
        LEN: begin
          if (po_flag && !len_bad) begin
            len_q  <= rx_data[4:0];
            xor_q  <= xor_q ^ rx_data;
            wr_idx <= 5'd0;
          end
        end
        PAY: begin
          if (po_flag) begin
            xor_q  <= xor_q ^ rx_data;
            wr_idx <= wr_idx + 5'd1;
          end
        end
        CHK: begin
          if (po_flag) begin
            rd_idx <= 5'd0;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            rd_idx <= drain_last ? 5'd0 : (rd_idx + 5'd1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
